// File: rtl/regfile_sb_pkg.sv
// Shared constants and helpers for the general-register file with write-in-flight scoreboard.
package regfile_sb_pkg;

    localparam int DEF_DATA_W   = 32;
    localparam int DEF_REG_CNT  = 32;
    localparam int DEF_RD_PORTS = 2;
    localparam int DEF_CNT_W    = 2;

    localparam int REG_ZERO = 0;

    // Low bit of field k in a flat bus of fields that are w bits wide.
    function automatic int slice_lo(input int k, input int w);
        return k * w;
    endfunction

endpackage

// File: rtl/regfile_sb_cnt.sv
// Pending-writer counter for one register: saturating up/down with a synchronous clear.
module regfile_sb_cnt
    import regfile_sb_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt
);

    // Simultaneous inc/dec cancel; dec at zero and inc at max are absorbed.
    function automatic logic [CNT_W-1:0] sat_step(input logic [CNT_W-1:0] c,
                                                  input logic up, input logic dn);
        if (up && !dn && (c != {CNT_W{1'b1}})) return c + CNT_W'(1);
        if (dn && !up && (c != '0))            return c - CNT_W'(1);
        return c;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else begin
            cnt <= sat_step(cnt, inc, dec);
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// Register file with same-cycle write-through bypass, per-register pending counters
// that drive the decode stall, and a one-cycle-delayed commit trace.
module regfile_sb
    import regfile_sb_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int REG_CNT  = DEF_REG_CNT,
    parameter int RD_PORTS = DEF_RD_PORTS,
    parameter int CNT_W    = DEF_CNT_W,
    localparam int ADDR_W  = $clog2(REG_CNT)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [RD_PORTS*ADDR_W-1:0] rd_a,
    input  logic [RD_PORTS-1:0]        rd_use,
    output logic [RD_PORTS*DATA_W-1:0] rd_d,
    input  logic                       iss_valid,
    input  logic [ADDR_W-1:0]          iss_a3,
    output logic                       iss_ready,
    input  logic                       ret_valid,
    input  logic                       ret_we,
    input  logic [ADDR_W-1:0]          ret_a3,
    input  logic [DATA_W-1:0]          ret_wd,
    input  logic [31:0]                ret_pc,
    input  logic                       clr,
    output logic                       stall,
    output logic                       trace_valid,
    output logic [31:0]                trace_pc,
    output logic [ADDR_W-1:0]          trace_a3,
    output logic [DATA_W-1:0]          trace_wd
);

    localparam logic [ADDR_W-1:0] A_ZERO  = ADDR_W'(REG_ZERO);
    localparam logic [CNT_W-1:0]  CNT_MAX = {CNT_W{1'b1}};

    logic [DATA_W-1:0] regs [REG_CNT];
    logic [CNT_W-1:0]  cnt  [REG_CNT];

    logic                wr_en;
    logic                iss_fire;
    logic                iss_ret_hit;
    logic [RD_PORTS-1:0] port_stall;

    logic              trace_vld_p1;
    logic [31:0]       trace_pc_p1;
    logic [ADDR_W-1:0] trace_a3_p1;
    logic [DATA_W-1:0] trace_wd_p1;

    assign wr_en = ret_valid && ret_we && (ret_a3 != A_ZERO);

    // A retire to the same register frees a slot, so a saturated counter still accepts.
    assign iss_ret_hit = ret_valid && (ret_a3 == iss_a3);
    assign iss_ready   = !((iss_a3 != A_ZERO) && (cnt[iss_a3] == CNT_MAX) && !iss_ret_hit);
    assign iss_fire    = iss_valid && iss_ready && (iss_a3 != A_ZERO);

    assign cnt[0] = '0;

    for (genvar r = 1; r < REG_CNT; r++) begin : g_cnt
        regfile_sb_cnt #(.CNT_W(CNT_W)) u_cnt (
            .clk   (clk),
            .reset (reset),
            .clr   (clr),
            .inc   (iss_fire && (iss_a3 == ADDR_W'(r))),
            .dec   (ret_valid && (ret_a3 == ADDR_W'(r))),
            .cnt   (cnt[r])
        );
    end

    // A writer retiring this cycle covers one pending count via the bypass.
    for (genvar k = 0; k < RD_PORTS; k++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic              wr_hit;
        assign ra     = rd_a[slice_lo(k, ADDR_W) +: ADDR_W];
        assign wr_hit = wr_en && (ret_a3 == ra);
        assign rd_d[slice_lo(k, DATA_W) +: DATA_W] =
            (ra == A_ZERO) ? '0 : (wr_hit ? ret_wd : regs[ra]);
        assign port_stall[k] = rd_use[k] && (ra != A_ZERO) && (cnt[ra] > CNT_W'(wr_hit));
    end

    assign stall = (|port_stall) || (iss_valid && !iss_ready);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < REG_CNT; r++) regs[r] <= '0;
        end else if (wr_en) begin
            regs[ret_a3] <= ret_wd;
        end
    end

    // ---- stage p1: commit trace, one cycle behind the write ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            trace_vld_p1 <= 1'b0;
            trace_pc_p1  <= '0;
            trace_a3_p1  <= '0;
            trace_wd_p1  <= '0;
        end else begin
            trace_vld_p1 <= wr_en;
            if (wr_en) begin
                trace_pc_p1 <= ret_pc;
                trace_a3_p1 <= ret_a3;
                trace_wd_p1 <= ret_wd;
            end
        end
    end

    assign trace_valid = trace_vld_p1;
    assign trace_pc    = trace_pc_p1;
    assign trace_a3    = trace_a3_p1;
    assign trace_wd    = trace_wd_p1;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb built with four read ports.
module tb_regfile_sb;

    localparam int DW = 32;
    localparam int RC = 32;
    localparam int RP = 4;
    localparam int CW = 2;
    localparam int AW = 5;

    logic              clk;
    logic              reset;
    logic [RP*AW-1:0]  rd_a;
    logic [RP-1:0]     rd_use;
    logic [RP*DW-1:0]  rd_d;
    logic              iss_valid;
    logic [AW-1:0]     iss_a3;
    logic              iss_ready;
    logic              ret_valid;
    logic              ret_we;
    logic [AW-1:0]     ret_a3;
    logic [DW-1:0]     ret_wd;
    logic [31:0]       ret_pc;
    logic              clr;
    logic              stall;
    logic              trace_valid;
    logic [31:0]       trace_pc;
    logic [AW-1:0]     trace_a3;
    logic [DW-1:0]     trace_wd;

    int passed = 0;
    int total  = 0;
    int fails  = 0;

    regfile_sb #(.DATA_W(DW), .REG_CNT(RC), .RD_PORTS(RP), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .rd_a(rd_a), .rd_use(rd_use), .rd_d(rd_d),
        .iss_valid(iss_valid), .iss_a3(iss_a3), .iss_ready(iss_ready),
        .ret_valid(ret_valid), .ret_we(ret_we), .ret_a3(ret_a3), .ret_wd(ret_wd),
        .ret_pc(ret_pc), .clr(clr), .stall(stall), .trace_valid(trace_valid),
        .trace_pc(trace_pc), .trace_a3(trace_a3), .trace_wd(trace_wd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rdp(input int k);
        return rd_d[k*DW +: DW];
    endfunction

    task automatic set_rd(input int k, input int a);
        rd_a[k*AW +: AW] = AW'(a);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        iss_valid = 0; iss_a3 = '0;
        ret_valid = 0; ret_we = 0; ret_a3 = '0; ret_wd = '0; ret_pc = '0;
        clr = 0;
    endtask

    task automatic retire(input int a, input logic we, input logic [31:0] wd, input logic [31:0] pc);
        ret_valid = 1; ret_we = we; ret_a3 = AW'(a); ret_wd = wd; ret_pc = pc;
    endtask

    task automatic issue(input int a);
        iss_valid = 1; iss_a3 = AW'(a);
    endtask

    initial begin
        rd_a = '0; rd_use = '0;
        idle();
        reset = 1;
        #1;
        chk("rst_stall", {31'b0, stall}, 32'd0);
        chk("rst_iss_ready", {31'b0, iss_ready}, 32'd1);
        tick(); tick();
        reset = 0;
        #1;
        chk("rst_trace_valid", {31'b0, trace_valid}, 32'd0);
        chk("rst_trace_pc", trace_pc, 32'd0);
        chk("rst_trace_wd", trace_wd, 32'd0);
        for (int r = 0; r < RC; r++) begin
            set_rd(0, r); set_rd(1, r);
            #1;
            chk($sformatf("rst_rd0_r%0d", r), rdp(0), 32'd0);
            chk($sformatf("rst_rd1_r%0d", r), rdp(1), 32'd0);
        end

        // Write r5 with same-cycle bypass, then trace one cycle later.
        set_rd(0, 5); set_rd(1, 0);
        retire(5, 1, 32'h1234_5678, 32'h0000_0400);
        #1;
        chk("wr5_bypass", rdp(0), 32'h1234_5678);
        chk("wr5_no_trace_yet", {31'b0, trace_valid}, 32'd0);
        tick();
        idle();
        #1;
        chk("wr5_trace_valid", {31'b0, trace_valid}, 32'd1);
        chk("wr5_trace_a3", {27'b0, trace_a3}, 32'd5);
        chk("wr5_trace_wd", trace_wd, 32'h1234_5678);
        chk("wr5_trace_pc", trace_pc, 32'h0000_0400);
        chk("wr5_stored", rdp(0), 32'h1234_5678);
        set_rd(0, 0);
        retire(0, 1, 32'hDEAD_BEEF, 32'h0000_0404);
        #1;
        chk("wr0_bypass_zero", rdp(0), 32'd0);
        tick();
        idle();
        #1;
        chk("wr0_no_trace", {31'b0, trace_valid}, 32'd0);
        chk("wr0_stored_zero", rdp(0), 32'd0);
        chk("wr0_trace_a3_held", {27'b0, trace_a3}, 32'd5);

        // Issue r8, read-stall, then retire with bypass clears stall in the same cycle.
        issue(8);
        #1;
        chk("iss8_ready", {31'b0, iss_ready}, 32'd1);
        chk("iss8_no_stall", {31'b0, stall}, 32'd0);
        tick();
        idle();
        set_rd(0, 8); set_rd(1, 8); rd_use = 4'b0011;
        #1;
        chk("rd8_stall", {31'b0, stall}, 32'd1);
        tick();
        retire(8, 1, 32'hCAFE_0008, 32'h0000_0500);
        #1;
        chk("ret8_stall_clear", {31'b0, stall}, 32'd0);
        chk("ret8_bypass_p0", rdp(0), 32'hCAFE_0008);
        chk("ret8_bypass_p1", rdp(1), 32'hCAFE_0008);
        tick();
        idle();
        #1;
        chk("ret8_after_stall", {31'b0, stall}, 32'd0);
        chk("ret8_stored", rdp(0), 32'hCAFE_0008);
        chk("ret8_trace_a3", {27'b0, trace_a3}, 32'd8);
        rd_use = '0;

        // Saturate r3 at 3 writers.
        for (int i = 0; i < 3; i++) begin
            issue(3);
            #1;
            chk($sformatf("iss3_ready_%0d", i), {31'b0, iss_ready}, 32'd1);
            tick();
        end
        #1;
        chk("iss3_full_ready", {31'b0, iss_ready}, 32'd0);
        chk("iss3_full_stall", {31'b0, stall}, 32'd1);
        tick();
        retire(3, 0, 32'd0, 32'd0);
        #1;
        chk("iss3_ret_ready", {31'b0, iss_ready}, 32'd1);
        chk("iss3_ret_stall", {31'b0, stall}, 32'd0);
        tick();
        idle();
        set_rd(0, 3); rd_use = 4'b0001;
        #1;
        chk("cnt3_pending", {31'b0, stall}, 32'd1);
        retire(3, 0, 32'd0, 32'd0);
        #1;
        chk("cnt3_kill1_stall", {31'b0, stall}, 32'd1);
        tick();
        #1;
        chk("cnt3_kill2_stall", {31'b0, stall}, 32'd1);
        tick();
        retire(3, 1, 32'h0000_0033, 32'h0000_0600);
        #1;
        chk("cnt3_last_bypass_stall", {31'b0, stall}, 32'd0);
        chk("cnt3_last_bypass_data", rdp(0), 32'h0000_0033);
        tick();
        idle();
        #1;
        chk("cnt3_drained", {31'b0, stall}, 32'd0);
        rd_use = '0;

        // clr overrides a same-cycle issue; later retire must not underflow.
        issue(9); tick(); tick();
        clr = 1;
        #1;
        tick();
        idle();
        set_rd(0, 9); rd_use = 4'b0001;
        #1;
        chk("clr9_stall", {31'b0, stall}, 32'd0);
        retire(9, 0, 32'd0, 32'd0);
        tick();
        idle();
        issue(9);
        tick();
        idle();
        #1;
        chk("clr9_no_underflow", {31'b0, stall}, 32'd1);
        retire(9, 1, 32'h0000_0099, 32'h0000_0700);
        #1;
        chk("clr9_ret_stall", {31'b0, stall}, 32'd0);
        chk("clr9_ret_data", rdp(0), 32'h0000_0099);
        tick();
        idle();
        chk("clr9_reg8_kept", {31'b0, stall}, 32'd0);
        rd_use = '0;

        // Four ports on distinct and identical addresses.
        retire(11, 1, 32'h0000_BBBB, 32'h0000_0800);
        tick();
        idle();
        issue(12);
        tick();
        idle();
        set_rd(0, 10); set_rd(1, 10); set_rd(2, 11); set_rd(3, 12);
        rd_use = 4'b0111;
        retire(10, 1, 32'h0000_AAAA, 32'h0000_0804);
        #1;
        chk("p4_rd0", rdp(0), 32'h0000_AAAA);
        chk("p4_rd1", rdp(1), 32'h0000_AAAA);
        chk("p4_rd2", rdp(2), 32'h0000_BBBB);
        chk("p4_rd3", rdp(3), 32'd0);
        chk("p4_nostall", {31'b0, stall}, 32'd0);
        rd_use = 4'b1000;
        #1;
        chk("p4_p3_stall", {31'b0, stall}, 32'd1);
        tick();
        idle();
        set_rd(2, 12);
        rd_use = 4'b0100;
        #1;
        chk("p4_p2_stall", {31'b0, stall}, 32'd1);
        rd_use = 4'b1100;
        retire(12, 1, 32'h0000_000C, 32'h0000_0808);
        #1;
        chk("p4_both_clear", {31'b0, stall}, 32'd0);
        chk("p4_rd2_byp", rdp(2), 32'h0000_000C);
        chk("p4_rd3_byp", rdp(3), 32'h0000_000C);
        chk("p4_rd0_stored", rdp(0), 32'h0000_AAAA);
        tick();
        idle();
        rd_use = '0;

        // Asynchronous reset mid-cycle clears counters and registers at once.
        issue(4); tick(); tick();
        idle();
        set_rd(0, 4); set_rd(1, 5); rd_use = 4'b0001;
        #1;
        chk("ar_pre_stall", {31'b0, stall}, 32'd1);
        #1;
        reset = 1;
        #1;
        chk("ar_stall", {31'b0, stall}, 32'd0);
        chk("ar_ready", {31'b0, iss_ready}, 32'd1);
        chk("ar_rd5", rdp(1), 32'd0);
        chk("ar_trace", {31'b0, trace_valid}, 32'd0);
        tick();
        reset = 0;
        retire(4, 0, 32'd0, 32'd0);
        tick();
        idle();
        issue(4);
        tick();
        idle();
        #1;
        chk("ar_post_cnt1", {31'b0, stall}, 32'd1);
        retire(4, 0, 32'd0, 32'd0);
        tick();
        idle();
        #1;
        chk("ar_post_drained", {31'b0, stall}, 32'd0);
        rd_use = '0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
